// File: rtl/serial_encode.sv
// Serial frame transmitter: 12 host-written bytes shifted out MSB-first on a divided link clock.
// Optional REGISTER_READBACK_EN macro enables the parallel_out register read mux.
module serial_encode #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] address,
  input  logic [7:0] data_in,
  input  logic       write_en,
  output logic       serial_clock,
  output logic       serial_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] parallel_out
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [6:0] BitLast = 7'd95;

  state_e     state_q, state_d;
  logic [7:0] frame_q [12];
  logic [7:0] div_q, div_d;
  logic [6:0] bit_q, bit_d;
  logic       sclk_q, sclk_d;
  logic       start;
  logic       reg_wr;
  logic [2:0] bit_sel;

  // Host port is locked out only while shifting; the done cycle still accepts writes.
  assign start  = write_en && (address == 4'hF) && data_in[0] && (state_q != StShift);
  assign reg_wr = write_en && (address < 4'd12) && (state_q != StShift);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d = StShift;
          div_d   = 8'd0;
          bit_d   = 7'd0;
          sclk_d  = 1'b0;
        end
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d  = 8'd0;
          sclk_d = ~sclk_q;
          // Falling edge: advance to the next bit or finish the frame.
          if (sclk_q) begin
            if (bit_q == BitLast) begin
              state_d = StDone;
            end else begin
              bit_d = bit_q + 7'd1;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      div_q   <= 8'd0;
      bit_q   <= 7'd0;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 12; i++) begin
        frame_q[i] <= 8'h00;
      end
    end else if (reg_wr) begin
      frame_q[address] <= data_in;
    end
  end

  assign bit_sel      = ~bit_q[2:0];
  assign busy         = (state_q == StShift);
  assign done         = (state_q == StDone);
  assign serial_clock = busy & sclk_q;
  assign serial_data  = busy & frame_q[bit_q[6:3]][bit_sel];

`ifdef REGISTER_READBACK_EN
  always_comb begin
    parallel_out = 8'h00;
    if (address < 4'd12) begin
      parallel_out = frame_q[address];
    end else if (address == 4'hF) begin
      parallel_out = {7'b0, busy};
    end
  end
`else
  assign parallel_out = 8'h00;
`endif

endmodule

// File: tb/tb_serial_encode.sv
// Directed bench for serial_encode: frame capture, busy/done timing, lockout, reset abort,
// back-to-back frames and a CLK_DIV=1 instance.
module tb_serial_encode;

  logic       clock;
  logic       reset_n;
  logic [3:0] address;
  logic [7:0] data_in;
  logic       write_en;
  logic       sclk, sdata, busy, done;
  logic [7:0] pout;
  logic       sclk1, sdata1, busy1, done1;
  logic [7:0] pout1;

  serial_encode #(.CLK_DIV(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .data_in      (data_in),
    .write_en     (write_en),
    .serial_clock (sclk),
    .serial_data  (sdata),
    .busy         (busy),
    .done         (done),
    .parallel_out (pout)
  );

  serial_encode #(.CLK_DIV(1)) dut1 (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .data_in      (data_in),
    .write_en     (write_en),
    .serial_clock (sclk1),
    .serial_data  (sdata1),
    .busy         (busy1),
    .done         (done1),
    .parallel_out (pout1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame monitor for the CLK_DIV=4 instance, sampled on the falling system clock edge.
  logic        clr;
  logic [95:0] cap;
  logic        ps;
  int          cyc, ncap, busy_n, done_n, done_at;

  always @(negedge clock) begin
    if (clr) begin
      cap <= '0; ps <= 1'b0; cyc <= 0; ncap <= 0; busy_n <= 0; done_n <= 0; done_at <= 0;
    end else begin
      cyc <= cyc + 1;
      if (busy) busy_n <= busy_n + 1;
      if (done) begin
        done_n <= done_n + 1;
        if (done_n == 0) done_at <= cyc + 1;
      end
      if (sclk && !ps) begin
        cap  <= {cap[94:0], sdata};
        ncap <= ncap + 1;
      end
      ps <= sclk;
    end
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(posedge clock); #1;
    address = a; data_in = d; write_en = 1'b1;
    @(posedge clock); #1;
    write_en = 1'b0;
  endtask

  task automatic start_frame();
    @(posedge clock); #1;
    address = 4'hF; data_in = 8'h01; write_en = 1'b1; clr = 1'b1;
    @(posedge clock); #1;
    write_en = 1'b0; clr = 1'b0;
  endtask

  logic [7:0]  fb [12];
  logic [95:0] frame_exp;
  logic [95:0] cap1;
  logic        pb, ps1, pbusy1;
  int          busy1_n, done1_n, tog_err;

  initial begin
    fb = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hC8, 8'h00, 8'hD2, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    frame_exp = 96'h12345678_C800D200_01000000;
    reset_n = 1'b0; address = 4'h0; data_in = 8'h00; write_en = 1'b0; clr = 1'b1;

    // 1: reset state
    repeat (3) @(posedge clock); #1;
    check("rst_outs", {sclk, sdata, busy, done}, 4'b0000);
    check("rst_pout", pout, 8'h00);
    reset_n = 1'b1;
    clr = 1'b0;
`ifdef REGISTER_READBACK_EN
    for (int i = 0; i < 12; i++) begin
      address = 4'(i); #1;
      check("rst_readback", pout, 8'h00);
    end
`endif

    // 2: basic frame
    for (int i = 0; i < 12; i++) wr(4'(i), fb[i]);
    wr(4'hF, 8'hFE);
    repeat (3) @(posedge clock); #1;
    check("no_start_bit0_clear", busy, 1'b0);
`ifdef REGISTER_READBACK_EN
    for (int i = 0; i < 12; i++) begin
      address = 4'(i); #1;
      check("readback", pout, fb[i]);
    end
`endif
    start_frame();
    repeat (800) @(posedge clock); #1;
    check("t2_frame", cap, frame_exp);
    check("t2_nbits", ncap, 96);
    check("t2_busy_cycles", busy_n, 768);
    check("t2_done_count", done_n, 1);
    check("t2_done_latency", done_at, 769);

    // 3: writes and start ignored while busy
    start_frame();
    repeat (20) @(posedge clock);
    wr(4'h4, 8'hFF);
    wr(4'hF, 8'h01);
    repeat (800) @(posedge clock); #1;
    check("t3_frame", cap, frame_exp);
    check("t3_busy_cycles", busy_n, 768);
    check("t3_done_count", done_n, 1);
`ifdef REGISTER_READBACK_EN
    address = 4'h4; #1;
    check("t3_reg4_frozen", pout, 8'hC8);
`endif

    // 5: start in the done cycle
    start_frame();
    pb = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      pb = busy;
      @(posedge clock); #1;
    end
    check("t5_done_seen", done, 1'b1);
    check("t5_busy_before_done", pb, 1'b1);
    check("t5_busy_in_done", busy, 1'b0);
    address = 4'hF; data_in = 8'h01; write_en = 1'b1; clr = 1'b1;
    @(posedge clock); #1;
    write_en = 1'b0; clr = 1'b0;
    check("t5_busy_after_done", busy, 1'b1);
    repeat (800) @(posedge clock); #1;
    check("t5_frame", cap, frame_exp);
    check("t5_busy_cycles", busy_n, 768);
    check("t5_done_latency", done_at, 769);

    // 4: reset mid-frame at bit 40 (serial_clock high phase)
    start_frame();
    repeat (325) @(posedge clock); #1;
    check("t4_pre_sclk", {busy, sclk}, 2'b11);
    reset_n = 1'b0; #1;
    check("t4_reset_outs", {sclk, sdata, busy, done}, 4'b0000);
    check("t4_reset_pout", pout, 8'h00);
    @(posedge clock); #1;
    reset_n = 1'b1;
`ifdef REGISTER_READBACK_EN
    address = 4'h0; #1;
    check("t4_reg0_cleared", pout, 8'h00);
`endif
    start_frame();
    repeat (800) @(posedge clock); #1;
    check("t4_zero_frame", cap, 96'h0);
    check("t4_nbits", ncap, 96);
    check("t4_done_count", done_n, 1);

    // 6: CLK_DIV=1 instance
    for (int i = 0; i < 12; i++) wr(4'(i), fb[i]);
    start_frame();
    address = 4'hF;
    cap1 = '0; ps1 = 1'b0; pbusy1 = 1'b0; busy1_n = 0; done1_n = 0; tog_err = 0;
    for (int k = 0; k < 200; k++) begin
      if (busy1) busy1_n++;
      if (done1) done1_n++;
      if (busy1 && pbusy1 && (sclk1 == ps1)) tog_err++;
      if (sclk1 && !ps1) cap1 = {cap1[94:0], sdata1};
`ifdef REGISTER_READBACK_EN
      if (k == 10) check("t6_readback_busy", pout1, 8'h01);
`endif
      ps1 = sclk1;
      pbusy1 = busy1;
      @(posedge clock); #1;
    end
    check("t6_busy_cycles", busy1_n, 192);
    check("t6_done_count", done1_n, 1);
    check("t6_toggle_errors", tog_err, 0);
    check("t6_frame", cap1, frame_exp);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
